// File: rtl/load_pkg.sv
// Shared definitions for the load unit: op encodings, FSM states
// and the op-to-access-size helper.
package load_pkg;

    localparam logic [2:0] OP_FULL = 3'b000;
    localparam logic [2:0] OP_LBU  = 3'b001;
    localparam logic [2:0] OP_LB   = 3'b010;
    localparam logic [2:0] OP_LHU  = 3'b011;
    localparam logic [2:0] OP_LH   = 3'b100;
    localparam logic [2:0] OP_LWU  = 3'b101;
    localparam logic [2:0] OP_LW   = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_FULL = 2'd3
    } size_t;

    // Op 111 has no lane, so it is treated as byte-sized (never misaligned).
    function automatic size_t op_size(input logic [2:0] op);
        size_t sz;
        case (op)
            OP_FULL:       sz = SZ_FULL;
            OP_LHU, OP_LH: sz = SZ_HALF;
            OP_LWU, OP_LW: sz = SZ_WORD;
            default:       sz = SZ_BYTE;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/load_lane_ext.sv
// Combinational lane extraction and zero/sign extension of a
// DATA_W-bit bus word according to the load op and low address bits.
module load_lane_ext
    import load_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OB     = $clog2(DATA_W / 8)
) (
    input  logic [OB-1:0]     lo,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] ext
);

    logic [7:0]  b_lane;
    logic [15:0] h_lane;
    logic [31:0] w_lane;

    // Select the addressed lane, then extend it per op.
    always_comb begin
        b_lane = 8'(data >> {lo, 3'b000});
        h_lane = 16'(data >> {lo[OB-1:1], 4'b0000});
        w_lane = 32'(data >> {lo[OB-1], 5'b00000});
        ext    = '0;
        case (op)
            OP_FULL: ext = data;
            OP_LBU:  ext = DATA_W'(b_lane);
            OP_LB:   ext = DATA_W'($signed(b_lane));
            OP_LHU:  ext = DATA_W'(h_lane);
            OP_LH:   ext = DATA_W'($signed(h_lane));
            OP_LWU: begin
                if (DATA_W == 64) ext = DATA_W'(w_lane);
                else              ext = data;
            end
            OP_LW: begin
                if (DATA_W == 64) ext = DATA_W'($signed(w_lane));
                else              ext = data;
            end
            default: ext = '0;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Handshaked load unit: request -> aligned bus read -> extended response.
// Optional address-error detection is enabled by LOAD_ADEL_CHECK_EN.
module load_unit
    import load_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_op,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_exc
);

    localparam int OB = $clog2(DATA_W / 8);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              exc_q, exc_d;
    logic              mis;
    logic [DATA_W-1:0] ext;

    load_lane_ext #(
        .DATA_W(DATA_W),
        .OB    (OB)
    ) u_ext (
        .lo  (addr_q[OB-1:0]),
        .op  (op_q),
        .data(bus_rdata),
        .ext (ext)
    );

    // Flag an incoming request whose address is not size-aligned.
    always_comb begin
        mis = 1'b0;
`ifdef LOAD_ADEL_CHECK_EN
        case (op_size(req_op))
            SZ_HALF: mis = req_addr[0];
            SZ_WORD: mis = |req_addr[1:0];
            SZ_FULL: mis = |req_addr[OB-1:0];
            default: mis = 1'b0;
        endcase
`endif
    end

    // Next-state and datapath update for the IDLE/BUS/RESP sequence.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        op_d    = op_q;
        data_d  = data_q;
        exc_d   = exc_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    op_d   = req_op;
                    exc_d  = mis;
                    if (mis) begin
                        data_d  = '0;
                        state_d = RESP;
                    end else begin
                        state_d = BUS;
                    end
                end
            end
            BUS: begin
                if (bus_ack) begin
                    data_d  = ext;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            op_q    <= OP_FULL;
            data_q  <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            data_q  <= data_d;
            exc_q   <= exc_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign bus_req   = (state_q == BUS);
    assign rsp_valid = (state_q == RESP);
    assign bus_addr  = {addr_q[ADDR_W-1:OB], {OB{1'b0}}};
    assign rsp_data  = data_q;
    assign rsp_exc   = exc_q;

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: 32- and 64-bit instances run in lockstep
// against a behavioural load model.
module tb_load_unit;
    import load_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [2:0]  req_op;
    logic        bus_ack;
    logic [63:0] bus_rdata;
    logic        rsp_ready;

    logic        rr32, br32, rv32, re32;
    logic [31:0] ba32, rd32;
    logic        rr64, br64, rv64, re64;
    logic [31:0] ba64;
    logic [63:0] rd64;

    int total = 0;
    int bad   = 0;

    load_unit #(.DATA_W(32), .ADDR_W(32)) dut32 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(rr32),
        .req_addr(req_addr), .req_op(req_op),
        .bus_req(br32), .bus_addr(ba32),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata[31:0]),
        .rsp_valid(rv32), .rsp_ready(rsp_ready),
        .rsp_data(rd32), .rsp_exc(re32)
    );

    load_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(rr64),
        .req_addr(req_addr), .req_op(req_op),
        .bus_req(br64), .bus_addr(ba64),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .rsp_valid(rv64), .rsp_ready(rsp_ready),
        .rsp_data(rd64), .rsp_exc(re64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected extended data for a bus of w bits.
    function automatic logic [63:0] model_data(int w, logic [31:0] addr,
                                               logic [2:0] op, logic [63:0] rd);
        logic [63:0] m, d, v;
        int nb, lo;
        m  = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        d  = rd & m;
        nb = w / 8;
        lo = int'(addr % nb);
        v  = 64'h0;
        case (op)
            3'd0: v = d;
            3'd1, 3'd2: begin
                v = (d >> (8 * lo)) & 64'hFF;
                if (op == 3'd2 && v[7]) v = v - 64'h100;
            end
            3'd3, 3'd4: begin
                v = (d >> (16 * (lo / 2))) & 64'hFFFF;
                if (op == 3'd4 && v[15]) v = v - 64'h1_0000;
            end
            3'd5, 3'd6: begin
                if (w == 32) v = d;
                else begin
                    v = (d >> (32 * (lo / 4))) & 64'hFFFF_FFFF;
                    if (op == 3'd6 && v[31]) v = v - 64'h1_0000_0000;
                end
            end
            default: v = 64'h0;
        endcase
        return v & m;
    endfunction

    // Whether the request raises an address error on a w-bit bus.
    function automatic logic model_mis(int w, logic [31:0] addr, logic [2:0] op);
`ifdef LOAD_ADEL_CHECK_EN
        int sz;
        case (op)
            3'd0:       sz = w / 8;
            3'd3, 3'd4: sz = 2;
            3'd5, 3'd6: sz = 4;
            default:    sz = 1;
        endcase
        return (addr % sz) != 0;
`else
        return w == 0 && addr == 32'h0 && op == 3'd0;
`endif
    endfunction

    // One request; ack a cycles after bus_req rises, response held d cycles.
    task automatic run_txn(input logic [31:0] addr, input logic [2:0] op,
                           input logic [63:0] rd, input int a, input int d,
                           input bit spur, input string tag);
        logic        m32, m64;
        logic [63:0] e32, e64;
        int          r;
        m32 = model_mis(32, addr, op);
        m64 = model_mis(64, addr, op);
        e32 = m32 ? 64'h0 : model_data(32, addr, op, rd);
        e64 = m64 ? 64'h0 : model_data(64, addr, op, rd);
        r   = 2 + a + d;
        req_valid = 1'b1;
        req_addr  = addr;
        req_op    = op;
        bus_ack   = 1'b0;
        rsp_ready = 1'b0;
        bus_rdata = {$urandom, $urandom};
        @(posedge clk);
        for (int c = 1; c <= r + 1; c++) begin
            logic eb32, ev32, eb64, ev64, ery;
            @(negedge clk);
            eb32 = !m32 && c <= 1 + a;
            eb64 = !m64 && c <= 1 + a;
            ev32 = m32 ? (c <= r) : (c >= 2 + a && c <= r);
            ev64 = m64 ? (c <= r) : (c >= 2 + a && c <= r);
            ery  = (c == r + 1);
            total++;
            if (br32 !== eb32) begin
                bad++;
                $display("FAIL %s bus_req32 c=%0d got=%b exp=%b", tag, c, br32, eb32);
            end
            total++;
            if (br64 !== eb64) begin
                bad++;
                $display("FAIL %s bus_req64 c=%0d got=%b exp=%b", tag, c, br64, eb64);
            end
            total++;
            if (rv32 !== ev32 || rv64 !== ev64) begin
                bad++;
                $display("FAIL %s rsp_valid c=%0d got=%b/%b exp=%b/%b",
                         tag, c, rv32, rv64, ev32, ev64);
            end
            total++;
            if (rr32 !== ery || rr64 !== ery) begin
                bad++;
                $display("FAIL %s req_ready c=%0d got=%b/%b exp=%b",
                         tag, c, rr32, rr64, ery);
            end
            if (eb32) begin
                total++;
                if (ba32 !== (addr & ~32'h3)) begin
                    bad++;
                    $display("FAIL %s bus_addr32 c=%0d got=%h exp=%h",
                             tag, c, ba32, addr & ~32'h3);
                end
            end
            if (eb64) begin
                total++;
                if (ba64 !== (addr & ~32'h7)) begin
                    bad++;
                    $display("FAIL %s bus_addr64 c=%0d got=%h exp=%h",
                             tag, c, ba64, addr & ~32'h7);
                end
            end
            if (ev32) begin
                total++;
                if (rd32 !== e32[31:0] || re32 !== m32) begin
                    bad++;
                    $display("FAIL %s rsp32 c=%0d got=%h/%b exp=%h/%b",
                             tag, c, rd32, re32, e32[31:0], m32);
                end
            end
            if (ev64) begin
                total++;
                if (rd64 !== e64 || re64 !== m64) begin
                    bad++;
                    $display("FAIL %s rsp64 c=%0d got=%h/%b exp=%h/%b",
                             tag, c, rd64, re64, e64, m64);
                end
            end
            req_valid = (c <= r) ? 1'($urandom % 2) : 1'b0;
            req_addr  = $urandom;
            req_op    = 3'($urandom);
            bus_ack   = (c == 1 + a) ||
                        (spur && c > 1 + a && c <= r && ($urandom % 2) == 1);
            bus_rdata = (c == 1 + a) ? rd : {$urandom, $urandom};
            rsp_ready = (c == r);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_op    = 3'd0;
        bus_ack   = 1'b0;
        bus_rdata = 64'h0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (rr32 !== 1'b1 || br32 !== 1'b0 || ba32 !== 32'h0 ||
            rv32 !== 1'b0 || rd32 !== 32'h0 || re32 !== 1'b0) begin
            bad++;
            $display("FAIL reset32 got rr=%b br=%b ba=%h rv=%b rd=%h re=%b exp 1 0 0 0 0 0",
                     rr32, br32, ba32, rv32, rd32, re32);
        end
        total++;
        if (rr64 !== 1'b1 || br64 !== 1'b0 || ba64 !== 32'h0 ||
            rv64 !== 1'b0 || rd64 !== 64'h0 || re64 !== 1'b0) begin
            bad++;
            $display("FAIL reset64 got rr=%b br=%b ba=%h rv=%b rd=%h re=%b exp 1 0 0 0 0 0",
                     rr64, br64, ba64, rv64, rd64, re64);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_txn(32'h1003, OP_LB, {32'h0, 32'h80FF_1234}, 3, 0, 0, "lb_1003");
        total++;
        if (rd32 !== 32'hFFFF_FF80) begin
            bad++;
            $display("FAIL lb_1003_hold got=%h exp=ffffff80", rd32);
        end
        run_txn(32'h2002, OP_LHU, {32'h0, 32'hBEEF_0001}, 0, 0, 0, "lhu_2002");
        total++;
        if (rd32 !== 32'h0000_BEEF) begin
            bad++;
            $display("FAIL lhu_2002_hold got=%h exp=0000beef", rd32);
        end
        run_txn(32'h0000_5004, OP_LW, 64'h9000_0000_1111_1111, 1, 1, 0, "lw_5004");
        total++;
        if (rd64 !== 64'hFFFF_FFFF_9000_0000) begin
            bad++;
            $display("FAIL lw_5004_hold got=%h exp=ffffffff90000000", rd64);
        end
        run_txn(32'h0000_5004, OP_LWU, 64'h9000_0000_1111_1111, 0, 0, 0, "lwu_5004");
        total++;
        if (rd64 !== 64'h0000_0000_9000_0000) begin
            bad++;
            $display("FAIL lwu_5004_hold got=%h exp=0000000090000000", rd64);
        end
        run_txn(32'h0000_7005, 3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, "op111");
    endtask

    task automatic test_backpressure();
        run_txn(32'h6000, OP_FULL, {$urandom, $urandom}, 2, 5, 1, "backpressure");
    endtask

    task automatic test_misaligned();
        run_txn(32'h3001, OP_LH, 64'h0000_0000_ABCD_8765, 0, 1, 1, "lh_3001");
        run_txn(32'h3004, OP_FULL, {$urandom, $urandom}, 1, 0, 0, "full_3004");
        run_txn(32'h3002, OP_LW, {$urandom, $urandom}, 0, 0, 0, "lw_3002");
    endtask

    task automatic test_reset_abort();
        req_valid = 1'b1;
        req_addr  = 32'h4000;
        req_op    = OP_FULL;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if (br32 !== 1'b1 || br64 !== 1'b1) begin
            bad++;
            $display("FAIL abort_busreq got=%b/%b exp=1/1", br32, br64);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (br32 !== 1'b0 || br64 !== 1'b0 || rr32 !== 1'b1 || rr64 !== 1'b1) begin
            bad++;
            $display("FAIL abort_async got br=%b/%b rr=%b/%b exp br=0/0 rr=1/1",
                     br32, br64, rr32, rr64);
        end
        @(negedge clk);
        reset     = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = {$urandom, $urandom};
        @(negedge clk);
        bus_ack = 1'b0;
        total++;
        if (br32 !== 1'b0 || br64 !== 1'b0 || rv32 !== 1'b0 || rv64 !== 1'b0 ||
            rr32 !== 1'b1 || rr64 !== 1'b1) begin
            bad++;
            $display("FAIL abort_late_ack got br=%b/%b rv=%b/%b rr=%b/%b exp 0/0 0/0 1/1",
                     br32, br64, rv32, rv64, rr32, rr64);
        end
        run_txn(32'h4008, OP_LHU, {$urandom, $urandom}, 1, 0, 0, "after_abort");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            run_txn($urandom, 3'($urandom_range(0, 6)), {$urandom, $urandom},
                    0, 0, 0, "b2b");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++)
            run_txn($urandom, 3'($urandom), {$urandom, $urandom},
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom % 2), "random");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_misaligned();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
